// File: rtl/memory_responder.sv
// Target side of the Memory_Interface request protocol: a word-organised RAM
// that services one byte-masked read or write at a time after a fixed latency.
module memory_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter logic        READ    = 1'b0,
    parameter logic        WRITE   = 1'b1
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        memory_state,
    input  logic [3:0]  frame_mask,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        memory_done,
    output logic        busy,
    output logic        access_error
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic [3:0]  r_mask;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;
    logic        r_done;
    logic        r_err;
    logic        r_busy;

    logic [31:0] r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic [31:0]   w_word;
    logic [31:0]   w_rd_masked;
    logic          w_unused;

    // Byte offset bits never take part in word addressing.
    assign w_unused = &{1'b0, address[1:0]};

    assign w_idx  = r_addr[AW-1:0];
    assign w_oor  = |r_addr[29:AW];
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_rd_masked = 32'h0;
        for (int b = 0; b < 4; b++) begin
            w_rd_masked[8*b +: 8] = r_mask[b] ? w_word[8*b +: 8] : 8'h00;
        end
    end

    // DONE is a one-cycle commit state; the registered done/error/data outputs
    // it produces appear in the following IDLE cycle, which is what lets a
    // held enable restart there and stream at one request per LATENCY+1 cycles.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rw        <= READ;
            r_mask      <= 4'h0;
            r_addr      <= 30'h0;
            r_wdata     <= 32'h0;
            r_read_data <= 32'h0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= enable;
                    if (enable) begin
                        r_rw    <= memory_state;
                        r_mask  <= frame_mask;
                        r_addr  <= address[31:2];
                        r_wdata <= write_data;
                        r_cnt   <= LAT_M1;
                        r_state <= (LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        // Leave as the counter reaches zero.
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt <= 4'd1) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_err   <= w_oor;
                    if (r_rw == READ) begin
                        r_read_data <= w_oor ? 32'h0 : w_rd_masked;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM has no reset; a request aborted by reset never reaches DONE.
    always_ff @(posedge CLK) begin
        if (r_state == S_DONE && r_rw == WRITE && !w_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (r_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign read_data    = r_read_data;
    assign memory_done  = r_done;
    assign busy         = r_busy;
    assign access_error = r_err;

endmodule

// File: tb/tb_memory_responder.sv
// Directed vector bench for memory_responder at DEPTH=1024, LATENCY=2.
module tb_memory_responder;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        memory_state = 1'b0;
    logic [3:0]  frame_mask = 4'h0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        memory_done;
    logic        busy;
    logic        access_error;

    memory_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
        .CLK(CLK), .reset_n(reset_n), .enable(enable), .memory_state(memory_state),
        .frame_mask(frame_mask), .address(address), .write_data(write_data),
        .read_data(read_data), .memory_done(memory_done), .busy(busy),
        .access_error(access_error)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        rw;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t v[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request starting just after a rising edge; returns the number
    // of edges until memory_done is seen (20 means it never came).
    task automatic do_req(input logic rw, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic err, output int lat);
        memory_state = rw;
        frame_mask   = m;
        address      = a;
        write_data   = wd;
        enable       = 1'b1;
        lat          = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (memory_done !== 1'b1 && lat < 20);
        rd     = read_data;
        err    = access_error;
        enable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          pulses;
        logic [31:0] pre[3];

        pre[0] = 32'h01020304;
        pre[1] = 32'h05060708;
        pre[2] = 32'h090A0B0C;

        v[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
        v[1]  = '{1'b0, 4'hF, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        v[2]  = '{1'b1, 4'h5, 32'h10,       32'h11223344, 32'hDEADBEEF, 1'b0};
        v[3]  = '{1'b0, 4'hF, 32'h10,       32'h0,        32'hDE22BE44, 1'b0};
        v[4]  = '{1'b0, 4'hC, 32'h10,       32'h0,        32'hDE220000, 1'b0};
        v[5]  = '{1'b1, 4'hF, 32'h0,        32'h01020304, 32'hDE220000, 1'b0};
        v[6]  = '{1'b1, 4'hF, 32'h4,        32'h05060708, 32'hDE220000, 1'b0};
        v[7]  = '{1'b1, 4'hF, 32'h8,        32'h090A0B0C, 32'hDE220000, 1'b0};
        v[8]  = '{1'b1, 4'hF, 32'h20,       32'h0,        32'hDE220000, 1'b0};
        v[9]  = '{1'b1, 4'hF, 32'h30,       32'h12345678, 32'hDE220000, 1'b0};
        v[10] = '{1'b0, 4'hF, 32'h1000,     32'h0,        32'h0,        1'b1};
        v[11] = '{1'b1, 4'hF, 32'h1000,     32'hFFFFFFFF, 32'h0,        1'b1};
        v[12] = '{1'b0, 4'hF, 32'h0,        32'h0,        32'h01020304, 1'b0};
        v[13] = '{1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
        v[14] = '{1'b1, 4'h0, 32'h4,        32'hFFFFFFFF, 32'h0,        1'b0};
        v[15] = '{1'b0, 4'hF, 32'h4,        32'h0,        32'h05060708, 1'b0};
        v[16] = '{1'b0, 4'hF, 32'h13,       32'h0,        32'hDE22BE44, 1'b0};
        v[17] = '{1'b0, 4'hF, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};

        // Reset state
        #12;
        check("rst_read_data", read_data, 32'h0);
        check("rst_done", {31'h0, memory_done}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, access_error}, 32'h0);
        @(negedge CLK);
        reset_n = 1'b1;
        @(posedge CLK); #1;

        // Table-driven single requests
        for (int i = 0; i < 18; i++) begin
            do_req(v[i].rw, v[i].m, v[i].a, v[i].wd, rd, err, lat);
            check($sformatf("v%0d_latency", i), lat, LAT + 1);
            check($sformatf("v%0d_read_data", i), rd, v[i].rd);
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, v[i].err});
            check($sformatf("v%0d_busy_in_done", i), {31'h0, busy}, 32'h1);
            @(posedge CLK); #1;
            check($sformatf("v%0d_done_pulse", i), {31'h0, memory_done}, 32'h0);
            check($sformatf("v%0d_busy_after", i), {31'h0, busy}, 32'h0);
        end

        // Abort: drop enable during WAIT of a write to 0x20
        memory_state = 1'b1; frame_mask = 4'hF; address = 32'h20; write_data = 32'hCAFEF00D;
        enable = 1'b1;
        @(posedge CLK); #1;
        check("abort_busy_wait", {31'h0, busy}, 32'h1);
        enable = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            if (memory_done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_busy_clear", {31'h0, busy}, 32'h0);
        check("abort_read_data_held", read_data, 32'h0);
        do_req(1'b0, 4'hF, 32'h20, 32'h0, rd, err, lat);
        check("abort_readback", rd, 32'h0);
        check("abort_readback_lat", lat, LAT + 1);
        @(posedge CLK); #1;

        // Back-to-back streaming reads with enable held
        memory_state = 1'b0; frame_mask = 4'hF; address = 32'h0; enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            do begin
                @(posedge CLK); #1;
                lat++;
            end while (memory_done !== 1'b1 && lat < 20);
            check($sformatf("stream%0d_spacing", k), lat, LAT + 1);
            check($sformatf("stream%0d_data", k), read_data, pre[k]);
            check($sformatf("stream%0d_busy", k), {31'h0, busy}, 32'h1);
            address = 32'(4 * (k + 1));
            if (k == 2) enable = 1'b0;
        end
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            if (memory_done === 1'b1) pulses++;
        end
        check("stream_stops", pulses, 0);

        // Asynchronous reset in WAIT of a write to 0x30
        memory_state = 1'b1; frame_mask = 4'hF; address = 32'h30; write_data = 32'hFFFF0000;
        enable = 1'b1;
        @(posedge CLK); #1;
        check("rstw_busy", {31'h0, busy}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("rstw_read_data", read_data, 32'h0);
        check("rstw_busy_clr", {31'h0, busy}, 32'h0);
        check("rstw_done", {31'h0, memory_done}, 32'h0);
        check("rstw_err", {31'h0, access_error}, 32'h0);
        enable = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset_n = 1'b1;
        @(posedge CLK); #1;
        do_req(1'b0, 4'hF, 32'h30, 32'h0, rd, err, lat);
        check("rstw_word_kept", rd, 32'h12345678);
        check("rstw_after_lat", lat, LAT + 1);
        check("rstw_after_err", {31'h0, err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Target-side end of the Memory_Interface request protocol: holds a word-organised RAM and services read/write requests issued by the fetch and load/store paths.
- Accepts one request at a time, waits a programmable latency, then returns data or commits the write and pulses memory_done.
- Sits between the core's memory interfaces and the simulated or synthesised instruction/data store.

Parameters:
- DEPTH, 1024, number of 32-bit words stored; power of two.
- LATENCY, 2, cycles from request acceptance to memory_done; legal range 1..15.
- READ, 1'b0, encoding of memory_state for a read.
- WRITE, 1'b1, encoding of memory_state for a write.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  request valid; must be held high until memory_done.
- memory_state  input  1  READ or WRITE.
- frame_mask  input  4  byte-lane enables; bit i selects data[8i+7:8i].
- address  input  32  byte address; bits [1:0] ignored.
- write_data  input  32  store data, valid while enable is high and memory_state is WRITE.
- read_data  output  32  load data, valid in the memory_done cycle and held afterwards.
- memory_done  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is in flight, from the cycle after acceptance through the DONE cycle.
- access_error  output  1  high together with memory_done when the address was out of range.

Behaviour:
- Reset, asserted asynchronously:
  - state goes to IDLE; read_data=0, memory_done=0, busy=0, access_error=0; counter=0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts the request; a pending write is never committed.
- Word index is address[log2(DEPTH)+1:2]. The address is out of range when address >= 4*DEPTH.
- States:
  - IDLE: when enable=1, latch memory_state, frame_mask, address and write_data into request registers, load counter=LATENCY-1, go to WAIT (or DONE if LATENCY=1).
  - WAIT: decrement counter each cycle; at counter=0, go to DONE.
  - DONE: memory_done=1 for exactly this cycle, then IDLE.
- Read completion, in the DONE cycle:
  - read_data bytes come from the latched word where frame_mask=1; bytes with mask=0 read as 0x00.
  - Out-of-range read: read_data=0 and access_error=1.
- Write completion, in the DONE cycle:
  - Only bytes whose latched mask bit is 1 are written.
  - Out-of-range write: RAM is untouched and access_error=1.
  - read_data is unchanged by writes.
- Abort: if enable drops while in WAIT, return to IDLE next edge. No memory_done, no write commit, read_data unchanged.
- Back-to-back: enable still high in the IDLE cycle after DONE starts a new request using the current address, so a fetcher holding enable streams accesses. Request throughput is one every LATENCY+1 cycles.
- Inputs changing during WAIT are ignored; the request registers are authoritative.
- frame_mask=4'b0000 completes normally: a read returns 0, a write changes nothing.
- memory_done and access_error are registered outputs. read_data is registered and holds between requests.

Test Plan:
- Reset, then WRITE addr 0x10, mask 1111, data 0xDEADBEEF, LATENCY=2 -> memory_done pulses 3 cycles after acceptance (the acceptance edge plus LATENCY edges); a following READ at 0x10 returns 0xDEADBEEF with access_error=0.
- WRITE 0x10 mask 0101 data 0x11223344 over 0xDEADBEEF -> READ mask 1111 returns 0xDE22BE44; READ mask 1100 returns 0xDE220000.
- READ addr 4*DEPTH (0x1000 at DEPTH=1024) -> memory_done=1 with access_error=1 and read_data=0; a WRITE there leaves word 0 unchanged.
- WRITE 0x20 data 0xCAFEF00D, drop enable in WAIT -> no memory_done pulse; a subsequent READ 0x20 returns the old contents (0x00000000 after preload of zeros).
- Hold enable high with address stepping 0,4,8 after each done -> three memory_done pulses spaced LATENCY+1 cycles apart, returning the preloaded words in order.
- Assert reset_n=0 asynchronously mid-WAIT of a write to 0x30 -> outputs go to 0 immediately, word 0x30 is unchanged, and a request accepted after release completes normally.
